isochronous_ce_fifo: RTL and testbench
======================================

Name: isochronous_ce_fifo

Overview:
Single-clock, multi-entry valid/ready buffer between two logical domains whose rates are integer fractions of clk_i, each marked by a clock-enable strobe (src_en_i, dst_en_i). It is the generalised successor of our 4-phase isochronous handshake: the two handshakes are decoupled by a parametrised-depth buffer instead of one outstanding token, data is carried internally, and occupancy is exposed. It sits wherever a fast and a divided datapath share a clock tree and are timed by STA through enables rather than separate clocks.

Parameters:
DataWidth, 32, payload width in bits (>=1).
Depth, 4, number of entries (>=1; need not be a power of two).
UsageWidth, $clog2(Depth+1), derived; width of usage_o.

Ports:
clk_i  input  1  clock; all state on posedge.
rst_ni  input  1  asynchronous active-low reset.
flush_i  input  1  synchronous clear of all entries.
src_en_i  input  1  source-side enable strobe; source handshake is evaluated only when high.
src_valid_i  input  1  source offers data.
src_ready_o  output  1  buffer accepts data this cycle.
src_data_i  input  DataWidth  source payload.
dst_en_i  input  1  destination-side enable strobe.
dst_valid_o  output  1  buffer presents data this cycle.
dst_ready_i  input  1  destination accepts data.
dst_data_o  output  DataWidth  head-of-buffer payload.
usage_o  output  UsageWidth  current number of stored entries.

Behaviour:
- Clock/reset: one clock (clk_i); reset rst_ni is asynchronous, active-low. Reset values: write/read pointers 0, count 0, src_ready_o = src_en_i (empty), dst_valid_o 0, usage_o 0, storage not reset (dst_data_o don't-care while dst_valid_o=0).
- src_ready_o = src_en_i && (count != Depth) && !flush_i. Push = src_valid_i && src_ready_o.
- dst_valid_o = dst_en_i && (count != 0) && !flush_i. Pop = dst_valid_o && dst_ready_i.
- dst_data_o = storage[rd_ptr] combinationally from registered storage; no fall-through: entry pushed at edge t is first visible to dst in cycle t+1 (latency 1 cycle minimum, then gated by next dst_en_i).
- Push writes storage[wr_ptr], wr_ptr advances; pop advances rd_ptr. Pointers wrap Depth-1 -> 0 (explicit compare, not power-of-two masking).
- count: +1 on push only, -1 on pop only, unchanged on both or neither. usage_o = count.
- Full (count==Depth): src_ready_o 0 even if a pop occurs same cycle (no ready-through-pop). Space freed by a pop is visible next cycle.
- Empty: dst_valid_o 0 even if a push occurs same cycle.
- Simultaneous push and pop with 0<count<Depth: both complete, count unchanged, FIFO order preserved.
- Depth==1: alternates full/empty; max throughput one item per two cycles when both enables are constantly high.
- flush_i: forces both readies/valids low in that cycle, next cycle pointers and count are 0; flush wins over any push/pop in the same cycle.
- Enables low: no handshake on that side; buffer state holds; other side unaffected.
- Reset mid-operation: all entries discarded immediately (asynchronous), outputs take reset values without waiting for a clock edge.
- Simulation-only assertions (guarded by SYNTHESIS / COMMON_CELLS_ASSERTS_OFF): src_valid_i && !src_ready_o && src_en_i implies src_valid_i and src_data_i stable until next src_en_i cycle; dst_valid_o && !dst_ready_i implies dst_valid_o and dst_data_o stable to the next dst_en_i cycle (no flush); Depth>=1 at elaboration.

Test Plan:
- Reset/idle: rst_ni low mid-stream with count=3 -> same cycle dst_valid_o=0, usage_o=0; after release with src_en_i=1 src_ready_o=1.
- Ratio 1:3 (src_en_i every cycle, dst_en_i every 3rd), Depth=4, push 0x10..0x17 continuously -> src_ready_o drops when usage_o=4, dst receives 0x10..0x17 in order, no loss/duplication.
- Full boundary: fill Depth=4, then push+pop same cycle -> pop completes, push refused, usage_o 3 next cycle, src_ready_o 1 next src_en_i cycle.
- Empty boundary/latency: empty buffer, push 0xA5 at edge t with dst_en_i=1 -> dst_valid_o=0 in cycle t, 1 with dst_data_o=0xA5 in cycle t+1.
- Wrap-around Depth=3: 10 items with random dst_ready_i backpressure -> in-order output, pointers wrap 2->0, usage_o never exceeds 3.
- Flush with count=2 and concurrent push/pop -> next cycle usage_o=0, dst_valid_o=0, neither handshake counted.

Source files
------------

// File: rtl/isochronous_ce_fifo.sv
// Single-clock valid/ready FIFO between two clock-enable timed domains.
// Handshakes are qualified by src_en_i / dst_en_i; storage is registered, so nothing falls through.
module isochronous_ce_fifo #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned Depth = 4,
    localparam int unsigned UsageWidth = $clog2(Depth + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  src_en_i,
    input  logic                  src_valid_i,
    output logic                  src_ready_o,
    input  logic [DataWidth-1:0]  src_data_i,
    input  logic                  dst_en_i,
    output logic                  dst_valid_o,
    input  logic                  dst_ready_i,
    output logic [DataWidth-1:0]  dst_data_o,
    output logic [UsageWidth-1:0] usage_o
);

    localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(Depth - 1);
    localparam logic [UsageWidth-1:0] FullCount = UsageWidth'(Depth);

    logic [DataWidth-1:0]  mem_q [Depth];
    logic [PtrWidth-1:0]   wr_ptr_q;
    logic [PtrWidth-1:0]   rd_ptr_q;
    logic [UsageWidth-1:0] count_q;
    logic                  push;
    logic                  pop;

    // Depth need not be a power of two, so wrap by explicit compare.
    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] ptr);
        return (ptr == LastPtr) ? '0 : ptr + 1'b1;
    endfunction

    // Readiness looks only at registered count: a pop never frees space in the same cycle.
    assign src_ready_o = src_en_i && (count_q != FullCount) && !flush_i;
    assign dst_valid_o = dst_en_i && (count_q != '0) && !flush_i;
    assign push        = src_valid_i && src_ready_o;
    assign pop         = dst_valid_o && dst_ready_i;
    assign dst_data_o  = mem_q[rd_ptr_q];
    assign usage_o     = count_q;

    // NOTE: the payload array is deliberately left out of reset; the count alone says what is valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= src_data_i;
        end
    end

    // NOTE: state registers use <= so every update sees the pre-edge values of its neighbours.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

`ifndef SYNTHESIS
`ifndef COMMON_CELLS_ASSERTS_OFF
    logic                 src_hold_q;
    logic                 dst_hold_q;
    logic [DataWidth-1:0] src_hold_data_q;
    logic [DataWidth-1:0] dst_hold_data_q;

    // Remember a stalled offer on each side until that side's next enabled cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            src_hold_q      <= 1'b0;
            dst_hold_q      <= 1'b0;
            src_hold_data_q <= '0;
            dst_hold_data_q <= '0;
        end else if (flush_i) begin
            src_hold_q <= 1'b0;
            dst_hold_q <= 1'b0;
        end else begin
            if (src_en_i) begin
                src_hold_q      <= src_valid_i && !src_ready_o;
                src_hold_data_q <= src_data_i;
            end
            if (dst_en_i) begin
                dst_hold_q      <= dst_valid_o && !dst_ready_i;
                dst_hold_data_q <= dst_data_o;
            end
        end
    end

    src_stable_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (src_hold_q && src_en_i && !flush_i) |-> (src_valid_i && (src_data_i == src_hold_data_q)))
        else $error("source offer withdrawn or changed while stalled");

    dst_stable_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (dst_hold_q && dst_en_i && !flush_i) |-> (dst_valid_o && (dst_data_o == dst_hold_data_q)))
        else $error("destination offer withdrawn or changed while stalled");

    if (Depth < 1) begin : g_bad_depth
        $error("Depth must be at least 1");
    end
`endif
`endif

endmodule

// File: tb/tb_isochronous_ce_fifo.sv
// Scoreboard bench for isochronous_ce_fifo: Depth=4 and Depth=3 instances share clock and reset.
module tb_isochronous_ce_fifo;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic       a_flush, a_src_en, a_src_valid, a_src_ready, a_dst_en, a_dst_valid, a_dst_ready;
    logic [7:0] a_src_data, a_dst_data;
    logic [2:0] a_usage;
    logic       b_flush, b_src_en, b_src_valid, b_src_ready, b_dst_en, b_dst_valid, b_dst_ready;
    logic [7:0] b_src_data, b_dst_data;
    logic [1:0] b_usage;

    logic [7:0] a_q[$];
    logic [7:0] b_q[$];
    int a_rcvd = 0;
    int b_rcvd = 0;

    isochronous_ce_fifo #(.DataWidth(8), .Depth(4)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(a_flush),
        .src_en_i(a_src_en), .src_valid_i(a_src_valid), .src_ready_o(a_src_ready), .src_data_i(a_src_data),
        .dst_en_i(a_dst_en), .dst_valid_o(a_dst_valid), .dst_ready_i(a_dst_ready), .dst_data_o(a_dst_data),
        .usage_o(a_usage)
    );

    isochronous_ce_fifo #(.DataWidth(8), .Depth(3)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(b_flush),
        .src_en_i(b_src_en), .src_valid_i(b_src_valid), .src_ready_o(b_src_ready), .src_data_i(b_src_data),
        .dst_en_i(b_dst_en), .dst_valid_o(b_dst_valid), .dst_ready_i(b_dst_ready), .dst_data_o(b_dst_data),
        .usage_o(b_usage)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the active edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Monitors: accepted pushes enter the queue, presented pops are compared against it.
    always @(negedge clk) begin
        if (!rst_n) begin
            a_q.delete();
        end else begin
            if (a_dst_valid && a_dst_ready) begin
                a_rcvd++;
                if (a_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL a_unexpected_pop: got 0x%0h expected nothing", a_dst_data);
                end else begin
                    check("a_data", 32'(a_dst_data), 32'(a_q.pop_front()));
                end
            end
            if (a_src_valid && a_src_ready) a_q.push_back(a_src_data);
            if (a_flush) a_q.delete();
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            b_q.delete();
        end else begin
            if (b_dst_valid && b_dst_ready) begin
                b_rcvd++;
                if (b_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL b_unexpected_pop: got 0x%0h expected nothing", b_dst_data);
                end else begin
                    check("b_data", 32'(b_dst_data), 32'(b_q.pop_front()));
                end
            end
            if (b_src_valid && b_src_ready) b_q.push_back(b_src_data);
            if (b_flush) b_q.delete();
        end
    end

    task automatic drain_a(input string name);
        a_src_valid = 1'b0;
        a_dst_en    = 1'b1;
        a_dst_ready = 1'b1;
        for (int n = 0; n < 20; n++) begin
            cyc();
            #3;
            if (a_usage == 0) break;
        end
        check({name, "_usage"}, 32'(a_usage), 0);
        check({name, "_queue"}, a_q.size(), 0);
    endtask

    initial begin
        int idx;
        int base;
        bit saw_full;
        logic [15:0] pat;

        rst_n = 1'b0;
        {a_flush, a_src_en, a_src_valid, a_dst_en, a_dst_ready} = '0;
        {b_flush, b_src_en, b_src_valid, b_dst_en, b_dst_ready} = '0;
        a_src_data = '0;
        b_src_data = '0;

        // Reset values: src_ready follows src_en, nothing presented.
        #2;
        a_src_en = 1'b1;
        #1;
        check("rst_src_ready_en1", 32'(a_src_ready), 1);
        check("rst_dst_valid", 32'(a_dst_valid), 0);
        check("rst_usage", 32'(a_usage), 0);
        a_src_en = 1'b0;
        #1;
        check("rst_src_ready_en0", 32'(a_src_ready), 0);
        cyc();
        rst_n = 1'b1;

        // Empty boundary: pushed entry appears one cycle later.
        cyc();
        a_src_en = 1'b1; a_dst_en = 1'b1; a_dst_ready = 1'b1;
        a_src_valid = 1'b1; a_src_data = 8'hA5;
        #3;
        check("lat_t_valid", 32'(a_dst_valid), 0);
        check("lat_t_ready", 32'(a_src_ready), 1);
        cyc();
        a_src_valid = 1'b0;
        #3;
        check("lat_t1_valid", 32'(a_dst_valid), 1);
        check("lat_t1_data", 32'(a_dst_data), 32'h0000_00A5);
        check("lat_t1_usage", 32'(a_usage), 1);
        cyc();
        #3;
        check("lat_drained_usage", 32'(a_usage), 0);

        // Ratio 1:3, push 0x10..0x17 continuously.
        idx = 0;
        saw_full = 1'b0;
        base = a_rcvd;
        for (int c = 0; c < 80; c++) begin
            cyc();
            a_src_en    = 1'b1;
            a_dst_en    = (c % 3 == 0);
            a_dst_ready = 1'b1;
            a_src_valid = (idx < 8);
            a_src_data  = 8'(16 + idx);
            #3;
            if (a_usage == 4) begin
                saw_full = 1'b1;
                check("ratio_full_ready", 32'(a_src_ready), 0);
            end
            if (a_src_valid && a_src_ready) idx++;
            if (idx == 8 && a_usage == 0) break;
        end
        a_src_valid = 1'b0;
        check("ratio_full_seen", 32'(saw_full), 1);
        check("ratio_count", a_rcvd - base, 8);
        check("ratio_queue", a_q.size(), 0);

        // Full boundary: pop while full does not admit a push that cycle.
        a_dst_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            a_src_valid = 1'b1;
            a_src_data  = 8'(8'h20 + i);
            #3;
            check("fill_ready", 32'(a_src_ready), 1);
        end
        cyc();
        a_dst_en = 1'b1; a_dst_ready = 1'b1;
        a_src_data = 8'h24;
        #3;
        check("full_src_ready", 32'(a_src_ready), 0);
        check("full_dst_valid", 32'(a_dst_valid), 1);
        check("full_head", 32'(a_dst_data), 32'h20);
        check("full_usage", 32'(a_usage), 4);
        cyc();
        a_dst_en = 1'b0;
        #3;
        check("after_pop_usage", 32'(a_usage), 3);
        check("after_pop_ready", 32'(a_src_ready), 1);
        cyc();
        a_src_valid = 1'b0;
        #3;
        check("refill_usage", 32'(a_usage), 4);
        drain_a("full_drain");

        // Flush with two entries and concurrent push/pop attempts.
        a_dst_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cyc();
            a_src_valid = 1'b1;
            a_src_data  = 8'(8'h30 + i);
            #3;
            check("pre_flush_ready", 32'(a_src_ready), 1);
        end
        cyc();
        a_flush = 1'b1;
        a_src_data = 8'h32;
        a_dst_en = 1'b1; a_dst_ready = 1'b1;
        #3;
        check("flush_src_ready", 32'(a_src_ready), 0);
        check("flush_dst_valid", 32'(a_dst_valid), 0);
        check("flush_usage", 32'(a_usage), 2);
        cyc();
        a_flush = 1'b0;
        a_src_valid = 1'b0;
        #3;
        check("post_flush_usage", 32'(a_usage), 0);
        check("post_flush_valid", 32'(a_dst_valid), 0);
        check("post_flush_queue", a_q.size(), 0);

        // Asynchronous reset with three entries stored.
        a_dst_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            a_src_valid = 1'b1;
            a_src_data  = 8'(8'h40 + i);
        end
        cyc();
        a_src_valid = 1'b0;
        a_dst_en = 1'b1; a_dst_ready = 1'b0;
        #1;
        check("pre_rst_valid", 32'(a_dst_valid), 1);
        check("pre_rst_usage", 32'(a_usage), 3);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", 32'(a_dst_valid), 0);
        check("rst_mid_usage", 32'(a_usage), 0);
        check("rst_mid_src_ready", 32'(a_src_ready), 1);
        cyc();
        rst_n = 1'b1;
        #3;
        check("rel_src_ready", 32'(a_src_ready), 1);
        check("rel_dst_valid", 32'(a_dst_valid), 0);
        check("rel_usage", 32'(a_usage), 0);
        a_dst_en = 1'b0;

        // Depth=3 wrap-around: 10 items with fixed backpressure pattern.
        pat = 16'hB2E5;
        idx = 0;
        saw_full = 1'b0;
        base = b_rcvd;
        for (int c = 0; c < 100; c++) begin
            cyc();
            b_src_en    = 1'b1;
            b_dst_en    = 1'b1;
            b_dst_ready = pat[c % 16];
            b_src_valid = (idx < 10);
            b_src_data  = 8'(8'h50 + idx);
            #3;
            if (b_usage == 3) begin
                saw_full = 1'b1;
                check("b_full_ready", 32'(b_src_ready), 0);
            end
            if (b_src_valid && b_src_ready) idx++;
            if (idx == 10 && b_usage == 0) break;
        end
        b_src_valid = 1'b0;
        check("b_full_seen", 32'(saw_full), 1);
        check("b_count", b_rcvd - base, 10);
        check("b_queue", b_q.size(), 0);

        cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
